// File: rtl/arrow_scheduler.sv
// arrow_scheduler: fetches note entries from a chart source, spawns falling
// arrows into a small pool of sprite slots and judges player steps.
//
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   enable           - run/freeze; when low everything holds and pulses are 0
//   frame_tick       - one-cycle pulse per video frame; moves arrows by SPEED
//   chart_req/ack    - entry handshake, chart_lane/delay/end carry the entry
//   step[3:0]        - one-cycle step pulse per lane (0 L, 1 D, 2 U, 3 R)
//   slot_valid/lane/y- per-slot sprite state for the renderer (packed)
//   hit_pulse        - at least one hit judged this cycle (registered)
//   miss_pulse       - at least one arrow fell past the window (registered)
//   score            - saturating hit counter
//   stall            - a spawn is waiting for a free slot
//   done             - chart finished and every slot empty
//   dbg_state        - current FSM state encoding, for checkers
//
// Handshake: chart_req is the ready-for-entry request, chart_ack marks the
// entry as valid. An entry is transferred on a rising edge where
// chart_req && chart_ack && enable; chart_req drops on that same edge, so
// the source sees it low in the following cycle. chart_req never depends
// combinationally on chart_ack.
module arrow_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int Y_W       = 10,
  parameter int SPAWN_Y   = 479,
  parameter int TARGET_Y  = 200,
  parameter int HIT_WIN   = 16,
  parameter int SPEED     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_tick,
  output logic                     chart_req,
  input  logic                     chart_ack,
  input  logic [1:0]               chart_lane,
  input  logic [7:0]               chart_delay,
  input  logic                     chart_end,
  input  logic [3:0]               step,
  output logic [NUM_SLOTS-1:0]     slot_valid,
  output logic [2*NUM_SLOTS-1:0]   slot_lane,
  output logic [Y_W*NUM_SLOTS-1:0] slot_y,
  output logic                     hit_pulse,
  output logic                     miss_pulse,
  output logic [15:0]              score,
  output logic                     stall,
  output logic                     done,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SPAWN = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [Y_W-1:0] WIN_LO  = Y_W'(TARGET_Y - HIT_WIN);
  localparam logic [Y_W-1:0] WIN_HI  = Y_W'(TARGET_Y + HIT_WIN);
  localparam logic [Y_W-1:0] SPD     = Y_W'(SPEED);
  localparam logic [Y_W-1:0] SPAWN_V = Y_W'(SPAWN_Y);

  state_t         state;
  logic [7:0]     delay_cnt;
  logic [1:0]     lane_lat;
  logic [Y_W-1:0] y_q    [NUM_SLOTS];
  logic [1:0]     lane_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] hit_mask;
  logic [NUM_SLOTS-1:0] miss_mask;
  logic [NUM_SLOTS-1:0] spawn_mask;
  logic [Y_W-1:0]       moved_y [NUM_SLOTS];
  logic                 free_found;
  logic                 lane_found;
  logic                 judge;
  logic [2:0]           hit_cnt;
  logic [16:0]          score_sum;
  logic [15:0]          score_next;

  assign dbg_state = state;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign slot_lane[2*g +: 2]   = lane_q[g];
    assign slot_y[Y_W*g +: Y_W]  = y_q[g];
  end

  always_comb begin
    hit_mask   = '0;
    miss_mask  = '0;
    spawn_mask = '0;
    free_found = 1'b0;
    lane_found = 1'b0;
    hit_cnt    = '0;
    judge      = enable && (state != S_IDLE);

    // One hit per lane: the lowest-index live slot of that lane whose
    // pre-move Y sits inside the window.
    for (int l = 0; l < 4; l++) begin
      lane_found = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (judge && step[l] && !lane_found && slot_valid[s] &&
            (lane_q[s] == 2'(l)) && (y_q[s] >= WIN_LO) && (y_q[s] <= WIN_HI)) begin
          hit_mask[s] = 1'b1;
          lane_found  = 1'b1;
        end
      end
      hit_cnt = hit_cnt + 3'(lane_found);
    end

    // A hit slot is never moved, so it can never also miss. No underflow:
    // a live Y is always >= WIN_LO and WIN_LO > SPEED.
    for (int s = 0; s < NUM_SLOTS; s++) begin
      moved_y[s]   = y_q[s] - SPD;
      miss_mask[s] = enable && frame_tick && slot_valid[s] && !hit_mask[s] &&
                     (moved_y[s] < WIN_LO);
    end

    // Free means free before this edge; slots released now are usable next cycle.
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!slot_valid[s] && !free_found) begin
        spawn_mask[s] = 1'b1;
        free_found    = 1'b1;
      end
    end

    score_sum  = {1'b0, score} + 17'(hit_cnt);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      delay_cnt  <= '0;
      lane_lat   <= '0;
      chart_req  <= 1'b0;
      slot_valid <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      stall      <= 1'b0;
      done       <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        y_q[s]    <= '0;
        lane_q[s] <= '0;
      end
    end else if (enable) begin
      hit_pulse  <= |hit_mask;
      miss_pulse <= |miss_mask;
      score      <= score_next;
      stall      <= (state == S_SPAWN) && !free_found;

      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (hit_mask[s] || miss_mask[s]) begin
          slot_valid[s] <= 1'b0;
          y_q[s]        <= '0;
          lane_q[s]     <= '0;
        end else if (frame_tick && slot_valid[s]) begin
          y_q[s] <= moved_y[s];
        end else if ((state == S_SPAWN) && spawn_mask[s]) begin
          slot_valid[s] <= 1'b1;
          y_q[s]        <= SPAWN_V;
          lane_q[s]     <= lane_lat;
        end
      end

      case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          chart_req <= 1'b1;
        end
        S_FETCH: begin
          if (chart_req && chart_ack) begin
            chart_req <= 1'b0;
            if (chart_end) begin
              state <= S_DRAIN;
            end else begin
              lane_lat  <= chart_lane;
              delay_cnt <= chart_delay;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Zero check comes first, so a zero delay costs exactly one cycle.
          if (delay_cnt == 8'd0) begin
            state <= S_SPAWN;
          end else if (frame_tick) begin
            delay_cnt <= delay_cnt - 8'd1;
          end
        end
        S_SPAWN: begin
          if (free_found) begin
            state     <= S_FETCH;
            chart_req <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (slot_valid == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          chart_req <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Directed testbench for arrow_scheduler (default parameters: 4 slots,
// spawn at Y=479, window 184..216, speed 2).
module tb_arrow_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        frame_tick;
  logic        chart_req;
  logic        chart_ack;
  logic [1:0]  chart_lane;
  logic [7:0]  chart_delay;
  logic        chart_end;
  logic [3:0]  step;
  logic [3:0]  slot_valid;
  logic [7:0]  slot_lane;
  logic [39:0] slot_y;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [15:0] score;
  logic        stall;
  logic        done;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];

  arrow_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_tick (frame_tick),
    .chart_req  (chart_req),
    .chart_ack  (chart_ack),
    .chart_lane (chart_lane),
    .chart_delay(chart_delay),
    .chart_end  (chart_end),
    .step       (step),
    .slot_valid (slot_valid),
    .slot_lane  (slot_lane),
    .slot_y     (slot_y),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .stall      (stall),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge and
  // outputs are sampled at the same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, then presents one entry for one cycle.
  task automatic serve(input logic [1:0] lane, input logic [7:0] dly, input logic is_end);
    int n;
    n = 0;
    while (!chart_req && n < 20) begin
      cyc();
      n++;
    end
    if (!chart_req) check("serve_req_timeout", chart_req, 1'b1);
    chart_ack   = 1'b1;
    chart_lane  = lane;
    chart_delay = dly;
    chart_end   = is_end;
    cyc();
    chart_ack   = 1'b0;
    chart_end   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; frame_tick = 1'b0; chart_ack = 1'b0;
    chart_lane = '0; chart_delay = '0; chart_end = 1'b0; step = '0;

    // Reset state
    do_reset();
    check("rst_valid", slot_valid, 4'h0);
    check("rst_lane",  slot_lane, 8'h0);
    check("rst_y",     slot_y, 40'h0);
    check("rst_req",   chart_req, 1'b0);
    check("rst_score", score, 16'h0);
    check("rst_done",  done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_state", dbg_state, 3'd0);

    // First fetch and spawn, lane 2 delay 0
    enable = 1'b1;
    cyc();
    check("req_after_enable", chart_req, 1'b1);
    serve(2'd2, 8'd0, 1'b0);
    check("req_drop", chart_req, 1'b0);
    cyc();
    check("no_spawn_yet", slot_valid, 4'h0);
    cyc();
    check("spawn_valid", slot_valid, 4'h1);
    check("spawn_lane",  slot_lane[1:0], 2'd2);
    check("spawn_y",     slot_y[9:0], 10'd479);
    check("second_req",  chart_req, 1'b1);

    // Trajectory with no steps, then miss at tick 148
    for (int k = 1; k <= 147; k++) exp_q.push_back(10'(479 - 2 * k));
    for (int k = 1; k <= 147; k++) begin
      tick();
      check("traj_y", slot_y[9:0], exp_q.pop_front());
    end
    check("alive_185", slot_valid, 4'h1);
    tick();
    check("miss_valid", slot_valid, 4'h0);
    check("miss_pulse", miss_pulse, 1'b1);
    check("miss_score", score, 16'd0);
    cyc();
    check("miss_pulse_1cyc", miss_pulse, 1'b0);

    // Hit at y=215 on lane 2; simultaneous lane 1 step finds nothing
    serve(2'd2, 8'd0, 1'b0);
    cyc();
    cyc();
    ticks(132);
    check("pre_hit_y", slot_y[9:0], 10'd215);
    step = 4'b0110;
    cyc();
    step = 4'b0000;
    check("hit_pulse", hit_pulse, 1'b1);
    check("hit_clear", slot_valid, 4'h0);
    check("hit_score", score, 16'd1);
    check("hit_no_miss", miss_pulse, 1'b0);
    cyc();
    check("hit_pulse_1cyc", hit_pulse, 1'b0);

    // Five entries, four slots: stall until the first miss frees slot 0
    serve(2'd0, 8'd0, 1'b0);
    serve(2'd1, 8'd0, 1'b0);
    serve(2'd3, 8'd0, 1'b0);
    serve(2'd0, 8'd0, 1'b0);
    serve(2'd1, 8'd0, 1'b0);
    cyc();
    cyc();
    check("full_valid", slot_valid, 4'hF);
    check("full_lanes", slot_lane, 8'b00_11_01_00);
    check("stall_set",  stall, 1'b1);
    check("stall_req",  chart_req, 1'b0);
    ticks(147);
    check("full_y3", slot_y[39:30], 10'd185);
    check("full_still_valid", slot_valid, 4'hF);
    tick();
    check("full_miss_valid", slot_valid, 4'h0);
    check("full_miss_pulse", miss_pulse, 1'b1);
    check("stall_held", stall, 1'b1);
    cyc();
    check("stall_clear", stall, 1'b0);
    check("fifth_valid", slot_valid, 4'h1);
    check("fifth_lane",  slot_lane[1:0], 2'd1);
    check("fifth_y",     slot_y[9:0], 10'd479);

    // Step and tick together at y=185: hit wins
    ticks(147);
    check("pre_tie_y", slot_y[9:0], 10'd185);
    step = 4'b0010;
    frame_tick = 1'b1;
    cyc();
    step = 4'b0000;
    frame_tick = 1'b0;
    check("tie_hit",   hit_pulse, 1'b1);
    check("tie_miss",  miss_pulse, 1'b0);
    check("tie_score", score, 16'd2);
    check("tie_valid", slot_valid, 4'h0);

    // Delay 3, then end marker, freeze, drain and done
    serve(2'd0, 8'd3, 1'b0);
    ticks(3);
    cyc();
    check("delay_no_spawn", slot_valid, 4'h0);
    cyc();
    check("delay_spawn", slot_valid, 4'h1);
    serve(2'd0, 8'd0, 1'b1);
    check("drain_state", dbg_state, 3'd4);
    check("drain_req", chart_req, 1'b0);
    ticks(10);
    check("pre_freeze_y", slot_y[9:0], 10'd459);
    enable = 1'b0;
    frame_tick = 1'b1;
    step = 4'b0001;
    for (int i = 0; i < 5; i++) cyc();
    frame_tick = 1'b0;
    step = 4'b0000;
    check("freeze_y", slot_y[9:0], 10'd459);
    check("freeze_hit", hit_pulse, 1'b0);
    check("freeze_state", dbg_state, 3'd4);
    enable = 1'b1;
    ticks(138);
    check("drain_miss_valid", slot_valid, 4'h0);
    check("drain_miss_pulse", miss_pulse, 1'b1);
    check("drain_not_done", done, 1'b0);
    cyc();
    check("done_set", done, 1'b1);
    check("done_state", dbg_state, 3'd5);
    check("done_score", score, 16'd2);
    cyc();
    check("done_held", done, 1'b1);

    // Reset mid-WAIT with a live slot
    do_reset();
    check("rst2_state", dbg_state, 3'd0);
    check("rst2_done",  done, 1'b0);
    check("rst2_score", score, 16'd0);
    serve(2'd3, 8'd0, 1'b0);
    cyc();
    cyc();
    check("rst2_spawn_lane", slot_lane[1:0], 2'd3);
    serve(2'd2, 8'd50, 1'b0);
    ticks(5);
    check("mid_wait_state", dbg_state, 3'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst3_valid", slot_valid, 4'h0);
    check("rst3_lane",  slot_lane, 8'h0);
    check("rst3_y",     slot_y, 40'h0);
    check("rst3_req",   chart_req, 1'b0);
    check("rst3_stall", stall, 1'b0);
    check("rst3_state", dbg_state, 3'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
